instr_fetch_unit: RTL and testbench

Initiator side of the instruction memory port. It owns the program counter, drives a byte address to the combinational little-endian instruction memory and captures the returned 32-bit word. Fetched {pc, instr} pairs go into a 2-entry prefetch buffer, which feeds the decode stage through a valid/ready handshake. Branch/jump redirects from execute flush the buffer and restart fetch at the new target.

---
 rtl/instr_fetch_pkg.sv | 21 ++
 rtl/instr_fetch_unit_buffer.sv | 73 +++++++
 rtl/instr_fetch_unit.sv | 92 +++++++++
 tb/tb_instr_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    // One prefetched instruction together with the byte address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_ZERO = '0;

    // Word-align a byte address by dropping its two low bits.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_buffer.sv
// Two-entry synchronous FIFO holding prefetched {pc, instr} pairs.
// Entry 0 is always the head; flush overrides push and pop.
module fetch_buffer
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entry0_q, entry1_q;
    fetch_entry_t entry0_d, entry1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_eff, push_eff;

    // A pop needs something to remove; a push needs a free slot (or one freed by the pop).
    assign pop_eff  = pop & (count_q != 2'd0);
    assign push_eff = push & ((count_q != 2'd2) | pop_eff);

    // Next-state of the storage: shift toward entry 0 on pop, append behind the last valid entry.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push_eff, pop_eff})
                2'b10: begin
                    if (count_q == 2'd0) entry0_d = push_data;
                    else                 entry1_d = push_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    entry0_d = entry1_q;
                    count_d  = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        entry0_d = push_data;
                    end else begin
                        entry0_d = entry1_q;
                        entry1_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry0_q <= ENTRY_ZERO;
            entry1_q <= ENTRY_ZERO;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    // Present zeros when empty so the decode side never sees stale data.
    assign head  = (count_q != 2'd0) ? entry0_q : ENTRY_ZERO;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction
// memory and queues fetched words for decode in a 2-entry prefetch buffer.
//
// Decode handshake: dec_valid says the head entry (dec_pc/dec_instr) is
// meaningful; a transfer happens on a rising edge where dec_valid and
// dec_ready are both high, except when redirect_valid is high in that cycle,
// which kills the transfer. While dec_valid=1 and dec_ready=0 the head is
// held stable.
module instr_fetch_unit
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 256,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err,
    output logic        oor_stall
);

    localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

    logic [31:0]  pc_q, pc_d;
    logic         misalign_q;
    logic [1:0]   buf_count;
    logic         pop, can_push, fetch;
    fetch_entry_t push_entry, head_entry;

    assign imem_addr = pc_q;
    assign oor_stall = (pc_q > LAST_ADDR);

    assign dec_valid = (buf_count != 2'd0);
    assign pop       = dec_valid & dec_ready;
    assign can_push  = (32'(buf_count) < BUF_DEPTH) | pop;
    assign fetch     = can_push & ~oor_stall & ~redirect_valid;

    assign push_entry = '{pc: pc_q, instr: imem_rdata};

    // Next PC: a redirect wins, then sequential advance on fetch, else hold.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (fetch) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Sticky flag for redirects whose target was not word aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;

    fetch_buffer u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (fetch),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .count     (buf_count),
        .head      (head_entry)
    );

    assign dec_instr = head_entry.instr;
    assign dec_pc    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;
    logic        oor_stall;

    int tests_run = 0;
    int tests_failed = 0;
    int accept_cnt = 0;

    logic [31:0] mem [64];
    logic [63:0] exp_q [$];

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err),
        .oor_stall      (oor_stall)
    );

    // Clock and memory model.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a <= 32'd252) return mem[a[7:2]];
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected fetch stream from a start address to the end of memory.
    task automatic sb_restart(input logic [31:0] start);
        exp_q.delete();
        for (logic [31:0] a = start; a <= 32'd252; a += 32'd4)
            exp_q.push_back({a, mem_word(a)});
    endtask

    // One cycle: sample away from the edge, score any accepted instruction, advance.
    task automatic tick();
        logic [63:0] e;
        #1;
        if (reset && dec_valid && dec_ready && !redirect_valid) begin
            accept_cnt++;
            if (exp_q.size() == 0) begin
                check32("sb_unexpected_pc", dec_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check32("sb_pc", dec_pc, e[63:32]);
                check32("sb_instr", dec_instr, e[31:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check32("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        check32("rst_dec_instr", dec_instr, 32'd0);
        check32("rst_dec_pc", dec_pc, 32'd0);
        check32("rst_misalign", {31'b0, misalign_err}, 32'd0);
        check32("rst_imem_addr", imem_addr, 32'd0);
        reset = 1'b1;
        sb_restart(32'h0);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        sb_restart({target[31:2], 2'b00});
        tick();
        redirect_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic        exp_mis;
        logic        exp_oor;
    } vec_t;

    vec_t vecs [6];
    int   acc0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | (i * 32'h0001_0101);
        mem[0] = 32'h0001_1020;
        mem[1] = 32'h0085_3022;
        mem[2] = 32'h0109_5024;

        vecs[0] = '{32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0016, 32'h0000_0014, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_00FC, 32'h0000_00FC, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0100, 32'h0000_0100, 1'b0, 1'b1};
        vecs[4] = '{32'h0000_0103, 32'h0000_0100, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_00F9, 32'h0000_00F8, 1'b1, 1'b0};

        // Stream with decode always ready.
        do_reset();
        dec_ready = 1'b1;
        check32("s1_valid_before_edge", {31'b0, dec_valid}, 32'd0);
        tick();
        check32("s1_valid_first", {31'b0, dec_valid}, 32'd1);
        check32("s1_pc0", dec_pc, 32'h0);
        check32("s1_instr0", dec_instr, 32'h0001_1020);
        tick();
        check32("s1_pc1", dec_pc, 32'h4);
        check32("s1_instr1", dec_instr, 32'h0085_3022);
        tick();
        check32("s1_pc2", dec_pc, 32'h8);
        check32("s1_instr2", dec_instr, 32'h0109_5024);
        tick();

        // Backpressure: buffer fills, PC holds, head stable.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            check32("s2_stall_instr", dec_instr, 32'h0001_1020);
            check32("s2_stall_pc", dec_pc, 32'h0);
            if (i >= 1) check32("s2_hold_addr", imem_addr, 32'h8);
        end
        dec_ready = 1'b1;
        acc0 = accept_cnt;
        for (int i = 0; i < 4; i++) begin
            check32("s2_no_gap", {31'b0, dec_valid}, 32'd1);
            tick();
        end
        check32("s2_accepts", accept_cnt - acc0, 4);

        // Redirect while the buffer is full and decode is accepting.
        do_reset();
        tick();
        tick();
        dec_ready = 1'b1;
        check32("s3_full_valid", {31'b0, dec_valid}, 32'd1);
        redirect(32'h10);
        check32("s3_valid_killed", {31'b0, dec_valid}, 32'd0);
        check32("s3_addr_target", imem_addr, 32'h10);
        tick();
        check32("s3_target_pc", dec_pc, 32'h10);
        for (int i = 0; i < 3; i++) tick();

        // Misaligned redirect: aligned fetch, sticky flag until reset.
        redirect(32'h16);
        check32("s4_addr", imem_addr, 32'h14);
        check32("s4_misalign", {31'b0, misalign_err}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check32("s4_sticky", {31'b0, misalign_err}, 32'd1);
        end
        do_reset();

        // Out of range: last two words drain, then fetch halts.
        dec_ready = 1'b1;
        redirect(32'hF8);
        for (int i = 0; i < 6; i++) tick();
        check32("s5_drained_all", exp_q.size(), 0);
        check32("s5_pc_oor", imem_addr, 32'h100);
        check32("s5_oor_stall", {31'b0, oor_stall}, 32'd1);
        check32("s5_valid_low", {31'b0, dec_valid}, 32'd0);
        redirect(32'h0);
        check32("s5_oor_clear", {31'b0, oor_stall}, 32'd0);
        tick();
        check32("s5_resume_valid", {31'b0, dec_valid}, 32'd1);
        check32("s5_resume_pc", dec_pc, 32'h0);
        tick();

        // Asynchronous reset between edges with a full buffer.
        do_reset();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check32("s6_async_valid", {31'b0, dec_valid}, 32'd0);
        check32("s6_async_addr", imem_addr, 32'h0);
        do_reset();
        dec_ready = 1'b1;
        tick();
        check32("s6_restart_pc", dec_pc, 32'h0);
        check32("s6_restart_instr", dec_instr, 32'h0001_1020);
        acc0 = accept_cnt;
        for (int i = 0; i < 3; i++) tick();
        check32("s6_restart_accepts", accept_cnt - acc0, 3);

        // Table of redirect targets from a fresh reset.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            redirect(vecs[v].target);
            check32("tbl_addr", imem_addr, vecs[v].exp_addr);
            check32("tbl_misalign", {31'b0, misalign_err}, {31'b0, vecs[v].exp_mis});
            check32("tbl_oor", {31'b0, oor_stall}, {31'b0, vecs[v].exp_oor});
            check32("tbl_valid", {31'b0, dec_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
